condicionador_botoes: RTL and testbench
=======================================

# condicionador_botoes

Conditions the three stopwatch command keys (conta, pausa, para) before they reach the state-machine block. Each raw key is synchronised, debounced and edge-detected, then the block emits at most one single-cycle command pulse per clock. The state machine therefore sees exactly one request per physical press, with fixed priority when presses coincide.

## Interface
- DEBOUNCE_CICLOS, 500000, consecutive stable samples required to accept a key change; 10 ms at 50 MHz. Benches use 4. Legal range is 2 to 2^24.
- ATIVO_BAIXO, 1, raw key polarity; 1 means the key reads 0 when pressed.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- conta_in  input  1  raw conta key, asynchronous to clk.
- pausa_in  input  1  raw pausa key, asynchronous to clk.
- para_in  input  1  raw para key, asynchronous to clk.
- conta_pulso  output  1  one-cycle conta command.
- pausa_pulso  output  1  one-cycle pausa command.
- para_pulso  output  1  one-cycle para command.
- nivel  output  3  debounced pressed levels, bit order {para, pausa, conta}, 1 = pressed.

## Operation
- Each key has its own channel:
  - A 2-flop synchroniser feeds a polarity fix, so the internal signal is 1 when pressed.
  - A stable-state register `estavel` and a counter sized to hold DEBOUNCE_CICLOS.
- Counter rules, per cycle:
  - If the synchronised sample equals `estavel`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter already holds DEBOUNCE_CICLOS-1 and the sample still differs, `estavel` takes the sample value and the counter clears.
- The channel raises a press pulse in the cycle after `estavel` goes 0→1. Release (1→0) produces no pulse.
- A held key produces exactly one pulse. Another pulse requires a debounced release followed by a debounced press.
- Arbitration when several channels pulse in the same cycle:
  - Priority is para > pausa > conta.
  - Only the winner drives its output; losing pulses are dropped, not queued.
  - At most one of the three pulse outputs is high in any cycle.
- `nivel` mirrors the three `estavel` registers directly.

## Timing
- Reset asserted, asynchronously:
  - All pulse outputs go to 0 and `nivel` goes to 000.
  - Counters clear.
  - Synchroniser flops take the released level.
- A key held down through reset release is treated as a new press. It pulses once after DEBOUNCE_CICLOS+3 edges, counting from the first edge after reset deasserts.
- Press latency: the raw key changes before edge 1 and stays clean.
  - Synchroniser output is valid after edge 2.
  - `estavel` sets at edge DEBOUNCE_CICLOS+2.
  - The pulse output is high for exactly one cycle, from edge DEBOUNCE_CICLOS+3 to edge DEBOUNCE_CICLOS+4.
- Glitches: a raw level lasting fewer than DEBOUNCE_CICLOS synchronised cycles never changes `estavel`. Any single matching sample restarts the count.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Sub-module `debounce_canal`, instantiated three times, containing:
  - synchroniser
  - polarity fix
  - counter
  - `estavel` register
  - rise detect
  - It takes DEBOUNCE_CICLOS and ATIVO_BAIXO as parameters and outputs a raw press pulse and its level.
- The top level holds only the arbitration and the output registers.
- Shared package or include file (reused by the state-machine block) holds:
  - button index constants: BOTAO_CONTA = 0, BOTAO_PAUSA = 1, BOTAO_PARA = 2;
  - the default DEBOUNCE_CICLOS value.

## Test plan
All scenarios use DEBOUNCE_CICLOS = 4 and ATIVO_BAIXO = 1.
- Clean press: conta_in 1→0 and held for 20 cycles. Required: conta_pulso high for exactly 1 cycle at edge 7, and nivel = 001 from edge 6. No pulse on release; nivel returns to 000 six edges after the release.
- Bounce: pausa_in toggles every 2 cycles for 12 cycles, then stays low. Required: zero pulses during bouncing, then exactly one pausa_pulso 7 edges after the last toggle.
- Glitch rejection: para_in low for 3 cycles, then high. Required: no para_pulso, nivel stays 000.
- Simultaneous press: all three keys go low on the same edge. Required: only para_pulso fires, once; conta_pulso and pausa_pulso stay 0 for the whole hold.
- Reset mid-operation: conta_in held low, reset pulsed low while the counter is 2. Required: outputs are 0 immediately; after reset release, exactly one conta_pulso at edge 7.
- Repeated presses: conta is pressed and released cleanly three times, each press lasting 10 cycles. Required: exactly 3 conta_pulso pulses, none overlapping with another output.

Source files
------------

// File: rtl/condicionador_botoes_pkg.sv
// Shared constants for the stopwatch command keys.
// Also used by the stopwatch state-machine block.
package condicionador_botoes_pkg;

   localparam int NUM_BOTOES = 3;

   localparam int BOTAO_CONTA = 0;
   localparam int BOTAO_PAUSA = 1;
   localparam int BOTAO_PARA  = 2;

   // 10 ms at 50 MHz
   localparam int DEBOUNCE_PADRAO = 500000;

   typedef logic [NUM_BOTOES-1:0] botoes_t;

   function automatic int largura_contador(input int ciclos);
      return (ciclos < 2) ? 1 : $clog2(ciclos + 1);
   endfunction

   // Fixed priority: para > pausa > conta; losers are dropped.
   function automatic botoes_t arbitra(input botoes_t pedido);
      botoes_t vence;
      vence = '0;
      priority case (1'b1)
         pedido[BOTAO_PARA]:  vence[BOTAO_PARA]  = 1'b1;
         pedido[BOTAO_PAUSA]: vence[BOTAO_PAUSA] = 1'b1;
         pedido[BOTAO_CONTA]: vence[BOTAO_CONTA] = 1'b1;
         default:             vence = '0;
      endcase
      return vence;
   endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Raw keys in, conditioned command pulses and levels out.
interface condicionador_botoes_if;
   import condicionador_botoes_pkg::*;

   logic    conta_in;
   logic    pausa_in;
   logic    para_in;
   logic    conta_pulso;
   logic    pausa_pulso;
   logic    para_pulso;
   botoes_t nivel;

   modport master (
      output conta_in,
      output pausa_in,
      output para_in,
      input  conta_pulso,
      input  pausa_pulso,
      input  para_pulso,
      input  nivel
   );

   modport slave (
      input  conta_in,
      input  pausa_in,
      input  para_in,
      output conta_pulso,
      output pausa_pulso,
      output para_pulso,
      output nivel
   );

endinterface

// File: rtl/debounce_canal.sv
// One key channel: synchroniser, polarity fix, debounce
// counter, stable level and press (rise) detect.
module debounce_canal
   import condicionador_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
   parameter bit ATIVO_BAIXO     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic tecla,
   output logic pulso,
   output logic nivel
);

   localparam int W = largura_contador(DEBOUNCE_CICLOS);
   localparam logic [W-1:0] LIMITE = W'(DEBOUNCE_CICLOS - 1);
   localparam logic SOLTO = ATIVO_BAIXO;

   logic         sinc_a;
   logic         sinc_b;
   logic         amostra;
   logic         estavel;
   logic         estavel_q;
   logic [W-1:0] contador;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sinc_a <= SOLTO;
         sinc_b <= SOLTO;
      end else begin
         sinc_a <= tecla;
         sinc_b <= sinc_a;
      end
   end

   assign amostra = sinc_b ^ ATIVO_BAIXO;

   // Any sample matching the stable level restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         contador <= '0;
         estavel  <= 1'b0;
      end else if (amostra == estavel) begin
         contador <= '0;
      end else if (contador == LIMITE) begin
         estavel  <= amostra;
         contador <= '0;
      end else begin
         contador <= contador + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estavel_q <= 1'b0;
      end else begin
         estavel_q <= estavel;
      end
   end

   assign pulso = estavel & ~estavel_q;
   assign nivel = estavel;

endmodule

// File: rtl/condicionador_botoes.sv
// Conditions the conta/pausa/para keys into single-cycle
// commands, one per press, with para > pausa > conta.
module condicionador_botoes
   import condicionador_botoes_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
   parameter bit ATIVO_BAIXO     = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   condicionador_botoes_if.slave bus
);

   botoes_t teclas;
   botoes_t pedido;
   botoes_t nivel_c;
   botoes_t vencedor;
   botoes_t saida_q;

   always_comb begin
      teclas              = '0;
      teclas[BOTAO_CONTA] = bus.conta_in;
      teclas[BOTAO_PAUSA] = bus.pausa_in;
      teclas[BOTAO_PARA]  = bus.para_in;
   end

   for (genvar i = 0; i < NUM_BOTOES; i++) begin : g_canal
      debounce_canal #(
         .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
         .ATIVO_BAIXO    (ATIVO_BAIXO)
      ) u_canal (
         .clk  (clk),
         .reset(reset),
         .tecla(teclas[i]),
         .pulso(pedido[i]),
         .nivel(nivel_c[i])
      );
   end

   always_comb begin
      vencedor = arbitra(pedido);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         saida_q <= '0;
      end else begin
         saida_q <= vencedor;
      end
   end

   assign bus.conta_pulso = saida_q[BOTAO_CONTA];
   assign bus.pausa_pulso = saida_q[BOTAO_PAUSA];
   assign bus.para_pulso  = saida_q[BOTAO_PARA];
   assign bus.nivel       = nivel_c;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios plus random
// key activity against a sample-window reference model.
module tb_condicionador_botoes;
   import condicionador_botoes_pkg::*;

   localparam int DC = 4;

   logic clk;
   logic reset;
   bit [2:0] pr;

   condicionador_botoes_if bus ();

   condicionador_botoes #(
      .DEBOUNCE_CICLOS(DC),
      .ATIVO_BAIXO    (1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Model: raw pressed history, synchronised samples,
   // stable levels, rises seen at the previous edge.
   bit hist[3][$];
   bit smp[3][$];
   bit [2:0] est_m;
   bit [2:0] rose_m;
   bit [2:0] exp_p;

   int edge_n;
   int cnt[3];
   int first[3];
   int multi;

   task automatic drive(input bit [2:0] p);
      pr = p;
      bus.conta_in = ~p[0];
      bus.pausa_in = ~p[1];
      bus.para_in  = ~p[2];
   endtask

   function automatic bit [2:0] obs_p();
      return {bus.para_pulso, bus.pausa_pulso, bus.conta_pulso};
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         hist[k].delete();
         smp[k].delete();
      end
      est_m  = '0;
      rose_m = '0;
      exp_p  = '0;
   endfunction

   // A level is accepted once the last DC samples all differ from it.
   function automatic void model_edge();
      bit [2:0] nova;
      if (!reset) begin
         model_reset();
         return;
      end
      exp_p = rose_m[2] ? 3'b100 :
              rose_m[1] ? 3'b010 :
              rose_m[0] ? 3'b001 : 3'b000;
      nova = '0;
      for (int k = 0; k < 3; k++) begin
         bit s;
         bit flip;
         int n;
         hist[k].push_back(pr[k]);
         if (hist[k].size() > 8) void'(hist[k].pop_front());
         n = hist[k].size();
         s = (n >= 3) ? hist[k][n-3] : 1'b0;
         smp[k].push_back(s);
         if (smp[k].size() > 8) void'(smp[k].pop_front());
         n = smp[k].size();
         flip = (n >= DC);
         for (int j = n - DC; j < n && flip; j++)
            if (smp[k][j] == est_m[k]) flip = 1'b0;
         if (flip) begin
            nova[k]  = !est_m[k];
            est_m[k] = !est_m[k];
         end
      end
      rose_m = nova;
   endfunction

   task automatic clear_stats();
      edge_n = 0;
      multi  = 0;
      for (int k = 0; k < 3; k++) begin
         cnt[k]   = 0;
         first[k] = -1;
      end
   endtask

   task automatic step();
      bit [2:0] o;
      @(posedge clk);
      model_edge();
      edge_n++;
      #1;
      o = obs_p();
      for (int k = 0; k < 3; k++) begin
         if (o[k]) begin
            cnt[k]++;
            if (first[k] < 0) first[k] = edge_n;
         end
      end
      if ($countones(o) > 1) multi++;
   endtask

   task automatic test_reset();
      drive(3'b000);
      reset = 1'b0;
      model_reset();
      clear_stats();
      repeat (2) step();
      total++;
      if (obs_p() !== 3'b000) begin
         bad++;
         $display("FAIL reset_pulse: got %b want 000", obs_p());
      end
      total++;
      if (bus.nivel !== 3'b000) begin
         bad++;
         $display("FAIL reset_nivel: got %b want 000", bus.nivel);
      end
      reset = 1'b1;
   endtask

   task automatic test_clean_press();
      int nv;
      clear_stats();
      nv = -1;
      drive(3'b001);
      for (int i = 0; i < 20; i++) begin
         step();
         if (nv < 0 && bus.nivel == 3'b001) nv = edge_n;
         total++;
         if (obs_p() !== exp_p || bus.nivel !== est_m) begin
            bad++;
            $display("FAIL clean e%0d: got p=%b n=%b want p=%b n=%b",
                     edge_n, obs_p(), bus.nivel, exp_p, est_m);
         end
      end
      total++;
      if (cnt[0] !== 1) begin
         bad++;
         $display("FAIL clean_count: got %0d want 1", cnt[0]);
      end
      total++;
      if (first[0] !== 7) begin
         bad++;
         $display("FAIL clean_edge: got %0d want 7", first[0]);
      end
      total++;
      if (nv !== 6) begin
         bad++;
         $display("FAIL clean_nivel_edge: got %0d want 6", nv);
      end
      clear_stats();
      nv = -1;
      drive(3'b000);
      for (int i = 0; i < 10; i++) begin
         step();
         if (nv < 0 && bus.nivel == 3'b000) nv = edge_n;
         total++;
         if (obs_p() !== exp_p || bus.nivel !== est_m) begin
            bad++;
            $display("FAIL release e%0d: got p=%b n=%b want p=%b n=%b",
                     edge_n, obs_p(), bus.nivel, exp_p, est_m);
         end
      end
      total++;
      if (cnt[0] + cnt[1] + cnt[2] !== 0) begin
         bad++;
         $display("FAIL release_pulse: got %0d want 0", cnt[0]);
      end
      total++;
      if (nv !== 6) begin
         bad++;
         $display("FAIL release_nivel_edge: got %0d want 6", nv);
      end
   endtask

   task automatic test_bounce();
      int last;
      clear_stats();
      for (int t = 0; t < 6; t++) begin
         drive((t % 2 == 0) ? 3'b010 : 3'b000);
         repeat (2) begin
            step();
            total++;
            if (obs_p() !== exp_p || bus.nivel !== est_m) begin
               bad++;
               $display("FAIL bounce e%0d: got p=%b n=%b want p=%b n=%b",
                        edge_n, obs_p(), bus.nivel, exp_p, est_m);
            end
         end
      end
      total++;
      if (cnt[0] + cnt[1] + cnt[2] !== 0) begin
         bad++;
         $display("FAIL bounce_quiet: got %0d want 0", cnt[1]);
      end
      last = edge_n;
      drive(3'b010);
      for (int i = 0; i < 14; i++) begin
         step();
         total++;
         if (obs_p() !== exp_p || bus.nivel !== est_m) begin
            bad++;
            $display("FAIL bounce_hold e%0d: got p=%b n=%b want p=%b n=%b",
                     edge_n, obs_p(), bus.nivel, exp_p, est_m);
         end
      end
      total++;
      if (cnt[1] !== 1 || first[1] !== last + 7) begin
         bad++;
         $display("FAIL bounce_pulse: got n=%0d at %0d want 1 at %0d",
                  cnt[1], first[1], last + 7);
      end
      drive(3'b000);
      repeat (10) step();
   endtask

   task automatic test_glitch();
      bit [2:0] nv_or;
      clear_stats();
      nv_or = '0;
      drive(3'b100);
      for (int i = 0; i < 12; i++) begin
         if (i == 3) drive(3'b000);
         step();
         nv_or |= bus.nivel;
         total++;
         if (obs_p() !== exp_p || bus.nivel !== est_m) begin
            bad++;
            $display("FAIL glitch e%0d: got p=%b n=%b want p=%b n=%b",
                     edge_n, obs_p(), bus.nivel, exp_p, est_m);
         end
      end
      total++;
      if (cnt[2] !== 0 || nv_or !== 3'b000) begin
         bad++;
         $display("FAIL glitch_reject: got n=%0d lvl=%b want 0 000",
                  cnt[2], nv_or);
      end
   endtask

   task automatic test_simultaneous();
      clear_stats();
      drive(3'b111);
      for (int i = 0; i < 15; i++) begin
         step();
         total++;
         if (obs_p() !== exp_p || bus.nivel !== est_m) begin
            bad++;
            $display("FAIL simul e%0d: got p=%b n=%b want p=%b n=%b",
                     edge_n, obs_p(), bus.nivel, exp_p, est_m);
         end
      end
      total++;
      if (cnt[2] !== 1 || first[2] !== 7) begin
         bad++;
         $display("FAIL simul_para: got n=%0d at %0d want 1 at 7",
                  cnt[2], first[2]);
      end
      total++;
      if (cnt[0] !== 0 || cnt[1] !== 0) begin
         bad++;
         $display("FAIL simul_losers: got conta=%0d pausa=%0d want 0 0",
                  cnt[0], cnt[1]);
      end
      drive(3'b000);
      repeat (10) step();
   endtask

   task automatic test_reset_mid();
      clear_stats();
      drive(3'b001);
      repeat (9) step();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      total++;
      if (obs_p() !== 3'b000 || bus.nivel !== 3'b000) begin
         bad++;
         $display("FAIL rst_async_held: got p=%b n=%b want 000 000",
                  obs_p(), bus.nivel);
      end
      step();
      reset = 1'b1;
      clear_stats();
      repeat (4) step();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      total++;
      if (obs_p() !== 3'b000 || bus.nivel !== 3'b000) begin
         bad++;
         $display("FAIL rst_async_cnt2: got p=%b n=%b want 000 000",
                  obs_p(), bus.nivel);
      end
      step();
      reset = 1'b1;
      clear_stats();
      for (int i = 0; i < 12; i++) begin
         step();
         total++;
         if (obs_p() !== exp_p || bus.nivel !== est_m) begin
            bad++;
            $display("FAIL rst_resume e%0d: got p=%b n=%b want p=%b n=%b",
                     edge_n, obs_p(), bus.nivel, exp_p, est_m);
         end
      end
      total++;
      if (cnt[0] !== 1 || first[0] !== 7) begin
         bad++;
         $display("FAIL rst_repress: got n=%0d at %0d want 1 at 7",
                  cnt[0], first[0]);
      end
      drive(3'b000);
      repeat (10) step();
   endtask

   task automatic test_repeated();
      clear_stats();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 20; i++) begin
            drive((i < 10) ? 3'b001 : 3'b000);
            step();
            total++;
            if (obs_p() !== exp_p || bus.nivel !== est_m) begin
               bad++;
               $display("FAIL repeat e%0d: got p=%b n=%b want p=%b n=%b",
                        edge_n, obs_p(), bus.nivel, exp_p, est_m);
            end
         end
      end
      total++;
      if (cnt[0] !== 3 || cnt[1] + cnt[2] !== 0 || multi !== 0) begin
         bad++;
         $display("FAIL repeat_count: got c=%0d o=%0d m=%0d want 3 0 0",
                  cnt[0], cnt[1] + cnt[2], multi);
      end
   endtask

   task automatic test_random();
      bit [2:0] p;
      clear_stats();
      p = '0;
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 3; k++)
            if ($urandom_range(0, 3) == 0) p[k] = !p[k];
         drive(p);
         step();
         total++;
         if (obs_p() !== exp_p || bus.nivel !== est_m) begin
            bad++;
            $display("FAIL random e%0d: got p=%b n=%b want p=%b n=%b",
                     edge_n, obs_p(), bus.nivel, exp_p, est_m);
         end
      end
      total++;
      if (multi !== 0) begin
         bad++;
         $display("FAIL random_onehot: got %0d want 0", multi);
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(3'b000);
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_repeated();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
